// File: rtl/dt_classify_arbiter_if.sv
// Bundle of requester, classifier and result signals for dt_classify_arbiter.
// The slave side is the arbiter; the master side is its surroundings.
interface dt_classify_arbiter_if #(
    parameter int unsigned N = 8,
    parameter int unsigned C = 3,
    parameter int unsigned R = 4
);
    localparam int unsigned IW = (R > 1) ? $clog2(R) : 1;

    logic [R-1:0]   req_valid;
    logic [R-1:0]   req_ready;
    logic [R*N-1:0] req_va, req_vb, req_vc, req_ia, req_ib, req_ic;
    logic [N-1:0]   dt_va, dt_vb, dt_vc, dt_ia, dt_ib, dt_ic;
    logic [C-1:0]   dt_cls;
    logic           out_valid;
    logic           out_ready;
    logic [C-1:0]   out_cls;
    logic [IW-1:0]  out_id;
    logic [15:0]    result_count;

    modport master (
        output req_valid, req_va, req_vb, req_vc, req_ia, req_ib, req_ic, dt_cls, out_ready,
        input  req_ready, dt_va, dt_vb, dt_vc, dt_ia, dt_ib, dt_ic, out_valid, out_cls,
        input  out_id, result_count
    );

    modport slave (
        input  req_valid, req_va, req_vb, req_vc, req_ia, req_ib, req_ic, dt_cls, out_ready,
        output req_ready, dt_va, dt_vb, dt_vc, dt_ia, dt_ib, dt_ic, out_valid, out_cls,
        output out_id, result_count
    );
endinterface

// File: rtl/dt_classify_arbiter.sv
// Round-robin arbiter sharing one combinational decision-tree classifier among R
// requesters: grant, drive registered feature bus, capture class, return tagged result.
module dt_classify_arbiter #(
    parameter int unsigned N = 8,
    parameter int unsigned C = 3,
    parameter int unsigned R = 4
) (
    input logic               clk,
    input logic               rst_n,
    dt_classify_arbiter_if.slave bus
);
    localparam int unsigned IW = (R > 1) ? $clog2(R) : 1;

    typedef enum logic [1:0] {StIdle, StEval, StHold} state_e;

    state_e        state_q, state_d;
    logic [IW-1:0] last_grant_q, gid_q;
    logic [N-1:0]  va_q, vb_q, vc_q, ia_q, ib_q, ic_q;
    logic [C-1:0]  out_cls_q;
    logic [IW-1:0] out_id_q;
    logic [15:0]   count_q, count_d;

    logic          grant_found;
    logic [IW-1:0] grant_idx;
    logic [IW-1:0] cand;
    logic [R-1:0]  req_ready;
    logic          out_valid;
    logic          accept;
    logic          handshake;

    // Search upward from last_grant+1, wrapping; i == R lands back on last_grant.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int unsigned i = 1; i <= R; i++) begin
            cand = IW'((32'(last_grant_q) + i) % R);
            if (!grant_found && bus.req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (grant_found) state_d = StEval;
            StEval:  state_d = StHold;
            StHold:  if (bus.out_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        req_ready = '0;
        out_valid = 1'b0;
        accept    = 1'b0;
        handshake = 1'b0;
        case (state_q)
            StIdle: begin
                if (grant_found) begin
                    req_ready[grant_idx] = 1'b1;
                    accept               = 1'b1;
                end
            end
            StHold: begin
                out_valid = 1'b1;
                handshake = bus.out_ready;
            end
            default: ;
        endcase
    end

    assign count_d = handshake ? count_q + 16'd1 : count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= IW'(R - 1);
            gid_q        <= '0;
            va_q         <= '0;
            vb_q         <= '0;
            vc_q         <= '0;
            ia_q         <= '0;
            ib_q         <= '0;
            ic_q         <= '0;
            out_cls_q    <= '0;
            out_id_q     <= '0;
            count_q      <= '0;
        end else begin
            if (accept) begin
                va_q         <= bus.req_va[grant_idx*N +: N];
                vb_q         <= bus.req_vb[grant_idx*N +: N];
                vc_q         <= bus.req_vc[grant_idx*N +: N];
                ia_q         <= bus.req_ia[grant_idx*N +: N];
                ib_q         <= bus.req_ib[grant_idx*N +: N];
                ic_q         <= bus.req_ic[grant_idx*N +: N];
                gid_q        <= grant_idx;
                last_grant_q <= grant_idx;
            end
            // Classifier output has had the whole EVAL cycle to settle.
            if (state_q == StEval) begin
                out_cls_q <= bus.dt_cls;
                out_id_q  <= gid_q;
            end
            count_q <= count_d;
        end
    end

    assign bus.req_ready    = req_ready;
    assign bus.out_valid    = out_valid;
    assign bus.out_cls      = out_cls_q;
    assign bus.out_id       = out_id_q;
    assign bus.result_count = count_q;
    assign bus.dt_va        = va_q;
    assign bus.dt_vb        = vb_q;
    assign bus.dt_vc        = vc_q;
    assign bus.dt_ia        = ia_q;
    assign bus.dt_ib        = ib_q;
    assign bus.dt_ic        = ic_q;
endmodule

// File: tb/tb_dt_classify_arbiter.sv
// Directed bench for dt_classify_arbiter with a small stand-in decision-tree classifier.
module tb_dt_classify_arbiter;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    logic [15:0] exp_count;

    dt_classify_arbiter_if #(.N(8), .C(3), .R(4)) bus ();

    dt_classify_arbiter #(.N(8), .C(3), .R(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // Stand-in classifier: ia>120 -> (va>128 ? 1 : 2); else ic>120 -> 3; else vb odd ? 4 : 5.
    function automatic logic [2:0] classify(input logic [7:0] va, input logic [7:0] vb,
                                            input logic [7:0] ia, input logic [7:0] ic);
        if (ia > 8'd120) return (va > 8'd128) ? 3'd1 : 3'd2;
        else if (ic > 8'd120) return 3'd3;
        else return vb[0] ? 3'd4 : 3'd5;
    endfunction

    assign bus.dt_cls = classify(bus.dt_va, bus.dt_vb, bus.dt_ia, bus.dt_ic);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int k, input logic [7:0] va, input logic [7:0] vb,
                           input logic [7:0] vc, input logic [7:0] ia, input logic [7:0] ib,
                           input logic [7:0] ic);
        bus.req_va[k*8 +: 8] = va;
        bus.req_vb[k*8 +: 8] = vb;
        bus.req_vc[k*8 +: 8] = vc;
        bus.req_ia[k*8 +: 8] = ia;
        bus.req_ib[k*8 +: 8] = ib;
        bus.req_ic[k*8 +: 8] = ic;
    endtask

    // Starts and ends at a falling edge in IDLE with out_ready held 1.
    task automatic do_txn(input string tag, input logic [3:0] valid, input logic [3:0] exp_rdy,
                          input int exp_id, input int exp_cls);
        bus.req_valid = valid;
        #1;
        chk({tag, "_grant"}, 32'(bus.req_ready), 32'(exp_rdy));
        @(negedge clk);
        bus.req_valid = 4'hF;
        #1;
        chk({tag, "_eval_ready"}, 32'(bus.req_ready), 32'd0);
        chk({tag, "_eval_valid"}, 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        chk({tag, "_hold_valid"}, 32'(bus.out_valid), 32'd1);
        chk({tag, "_id"}, 32'(bus.out_id), 32'(exp_id));
        chk({tag, "_cls"}, 32'(bus.out_cls), 32'(exp_cls));
        chk({tag, "_hold_ready"}, 32'(bus.req_ready), 32'd0);
        bus.req_valid = 4'h0;
        @(negedge clk);
        exp_count = exp_count + 16'd1;
        chk({tag, "_done_valid"}, 32'(bus.out_valid), 32'd0);
        chk({tag, "_count"}, 32'(bus.result_count), 32'(exp_count));
    endtask

    initial begin
        int n;
        logic [2:0] cls_tab [4];
        cls_tab[0] = 3'd2;
        cls_tab[1] = 3'd1;
        cls_tab[2] = 3'd3;
        cls_tab[3] = 3'd4;
        checks        = 0;
        failures      = 0;
        exp_count     = 16'd0;
        rst_n         = 1'b0;
        bus.req_valid = '0;
        bus.req_va    = '0;
        bus.req_vb    = '0;
        bus.req_vc    = '0;
        bus.req_ia    = '0;
        bus.req_ib    = '0;
        bus.req_ic    = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(bus.req_ready), 32'd0);
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_count", 32'(bus.result_count), 32'd0);
        chk("rst_dt_va", 32'(bus.dt_va), 32'd0);
        chk("rst_out_id", 32'(bus.out_id), 32'd0);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clk);

        // Single request from requester 2: ic=130 > 120 with ia=100 gives class 3.
        set_req(2, 8'd130, 8'd130, 8'd130, 8'd100, 8'd110, 8'd130);
        do_txn("single", 4'b0100, 4'b0100, 2, 3);
        chk("single_dt_va", 32'(bus.dt_va), 32'd130);
        chk("single_dt_ia", 32'(bus.dt_ia), 32'd100);
        chk("single_dt_ib", 32'(bus.dt_ib), 32'd110);

        // Reset so round robin restarts at 0, then all four requesters stream.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        exp_count = 16'd0;
        set_req(0, 8'd100, 8'd0, 8'd0, 8'd150, 8'd0, 8'd0);
        set_req(1, 8'd200, 8'd1, 8'd0, 8'd150, 8'd0, 8'd0);
        set_req(2, 8'd200, 8'd2, 8'd0, 8'd50, 8'd0, 8'd200);
        set_req(3, 8'd200, 8'd3, 8'd0, 8'd50, 8'd0, 8'd0);
        bus.req_valid = 4'hF;
        n = 0;
        for (int i = 1; i <= 18; i++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                chk("rr_id", 32'(bus.out_id), 32'(n % 4));
                chk("rr_cls", 32'(bus.out_cls), 32'(cls_tab[n % 4]));
                chk("rr_slot", 32'(i), 32'(3 * n + 2));
                n++;
            end
        end
        chk("rr_results", 32'(n), 32'd6);
        chk("rr_count", 32'(bus.result_count), 32'd6);
        exp_count = 16'd6;

        // Backpressure: last grant was 1, so requester 3 alone wins.
        bus.out_ready = 1'b0;
        bus.req_valid = 4'b1000;
        #1;
        chk("bp_grant", 32'(bus.req_ready), 32'b1000);
        @(negedge clk);
        bus.req_valid = 4'hF;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("bp_valid", 32'(bus.out_valid), 32'd1);
            chk("bp_id", 32'(bus.out_id), 32'd3);
            chk("bp_cls", 32'(bus.out_cls), 32'd4);
            chk("bp_ready", 32'(bus.req_ready), 32'd0);
            chk("bp_count", 32'(bus.result_count), 32'd6);
        end
        bus.req_valid = 4'h0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        exp_count = 16'd7;
        chk("bp_release_valid", 32'(bus.out_valid), 32'd0);
        chk("bp_release_count", 32'(bus.result_count), 32'd7);
        @(negedge clk);
        chk("bp_once_count", 32'(bus.result_count), 32'd7);

        // Skip and wrap from last_grant=3.
        do_txn("skip0", 4'b1001, 4'b0001, 0, 2);
        do_txn("skip3", 4'b1000, 4'b1000, 3, 4);
        do_txn("skip1", 4'b1010, 4'b0010, 1, 1);

        // Asynchronous reset while in EVAL drops the sample.
        bus.req_valid = 4'b0100;
        #1;
        chk("ar_grant", 32'(bus.req_ready), 32'b0100);
        @(negedge clk);
        bus.req_valid = 4'h0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_valid", 32'(bus.out_valid), 32'd0);
        chk("ar_count", 32'(bus.result_count), 32'd0);
        chk("ar_dt_va", 32'(bus.dt_va), 32'd0);
        chk("ar_dt_ic", 32'(bus.dt_ic), 32'd0);
        chk("ar_out_id", 32'(bus.out_id), 32'd0);
        chk("ar_out_cls", 32'(bus.out_cls), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("ar_no_result", 32'(bus.out_valid), 32'd0);
        end
        exp_count = 16'd0;
        do_txn("ar_next", 4'hF, 4'b0001, 0, 2);

        // Count wrap: preload 0xFFFF, one more handshake wraps to 0.
        force dut.count_q = 16'hFFFF;
        @(negedge clk);
        release dut.count_q;
        exp_count = 16'hFFFF;
        do_txn("wrap", 4'b0100, 4'b0100, 2, 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/dt_classify_arbiter.md
# dt_classify_arbiter

Round-robin scheduler that shares one combinational decision-tree classifier among R sample requesters. It accepts one six-feature sample (Va, Vb, Vc, Ia, Ib, Ic) per transaction over a valid/ready handshake. It drives the sample into the classifier through a registered feature bus and captures the class after one settle cycle. The class is returned on a valid/ready output tagged with the requester index. The block sits between the per-channel sample acquisition front ends and the single classifier instance.

## Interface
- N, 8, width of each feature (Va..Ic), matches classifier N
- C, 3, width of the class code, matches classifier C
- R, 4, number of requesters (2..16); IW = max(1, $clog2(R))
- clk  input  1  single clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  R  per-requester sample valid
- req_ready  output  R  per-requester accept, one-hot or zero
- req_va, req_vb, req_vc, req_ia, req_ib, req_ic  input  R*N each  packed features, requester k at bits [k*N +: N]
- dt_va, dt_vb, dt_vc, dt_ia, dt_ib, dt_ic  output  N each  registered feature bus to classifier inputs
- dt_cls  input  C  classifier class output (combinational from dt_*)
- out_valid  output  1  result available
- out_ready  input  1  downstream accepts result
- out_cls  output  C  captured class code
- out_id  output  IW  index of requester that supplied the sample
- result_count  output  16  number of completed output handshakes, wraps 0xFFFF->0

## Operation
- FSM states: IDLE, EVAL, HOLD.
- IDLE:
  - if any req_valid bit is set, grant g = first set bit searching upward from (last_grant+1) mod R, wrapping;
  - req_ready[g]=1 combinationally this cycle only;
  - load dt_* from requester g's slices, gid<=g, last_grant<=g, go to EVAL;
  - if no req_valid bit is set, stay in IDLE with req_ready=0.
- EVAL: hold dt_*; at the clock edge capture out_cls<=dt_cls and out_id<=gid; go to HOLD.
- HOLD:
  - out_valid=1;
  - out_cls and out_id are stable while out_valid=1 and out_ready=0;
  - on out_valid&&out_ready: result_count increments, go to IDLE.
- req_ready is 0 in EVAL and HOLD; requesters keep valid and data stable until their ready.
- Grant uses only req_valid sampled in IDLE; a requester deasserting valid before being granted is legal and simply skipped.
- dt_* hold their last value outside EVAL; no other block drives the classifier.
- Width rule: features pass through unmodified, no arithmetic; result_count is modulo 2^16.
- Fairness: with all R valid continuously, grants cycle 0,1,...,R-1,0,...; no requester waits more than R-1 other transactions.

## Timing
- Reset (rst_n=0, asynchronous, any state):
  - state=IDLE; last_grant=R-1, so requester 0 wins first;
  - dt_*=0, out_cls=0, out_id=0, out_valid=0, req_ready=0, result_count=0.
- Reset mid-transaction drops the accepted sample; no output is produced for it.
- Latency: accept at edge T (IDLE, valid&ready). Classifier settles during cycle T+1 (EVAL). out_valid rises after edge T+2.
- Minimum transaction period is 3 cycles with out_ready held 1. Every extra out_ready=0 cycle adds one cycle.
- Classifier combinational path must settle within one clk period (dt_* register to out_cls register).
- req_ready is a combinational function of state, last_grant and req_valid only; there is no path from out_ready to req_ready.
- Simultaneous events:
  - out handshake in HOLD and a new req_valid in the same cycle: the block returns to IDLE first and grants on the next cycle;
  - multiple req_valid in IDLE: exactly one grant per the round-robin rule.

## Test plan
- Reset then single request: req_valid=4'b0100, features Va..Ic=130,130,130,100,110,130 → req_ready=4'b0100 in the same cycle; out_valid 2 cycles later with out_cls = classifier class for those features and out_id=2; result_count=1 after the handshake.
- All four requesters valid continuously, out_ready=1 → out_id sequence 0,1,2,3,0,1; one out_valid every 3 cycles; result_count=6 after 18 cycles.
- Backpressure: out_ready=0 for 5 cycles in HOLD → out_cls and out_id stable, req_ready=0 throughout; on out_ready=1 exactly one handshake occurs and result_count increments once.
- Skip and wrap: last_grant=3, req_valid=4'b1001 → grant 0. Next request with only bit 3 set → grant 3. Then bits 1 and 3 set → grant 1.
- Async reset asserted in EVAL, then released → out_valid never rises for the dropped sample; all outputs are at reset values; the next grant goes to requester 0.
- result_count wrap: preload by running 65535 handshakes (or force), one more handshake → result_count=0.
